// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index width that never collapses to zero bits, so N=1 still gets a 1-bit id.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tristate_buf.sv
// W-bit tri-state buffer: drives y with a while enable is high, else floats.
module tristate_buf #(
  parameter int W = 4
) (
  input  logic         enable,
  input  logic [W-1:0] a,
  output wire  [W-1:0] y
);

  assign y = enable ? a : {W{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Rotating-priority search: first set req bit starting at ptr and wrapping.
module rr_pick
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2w(N)-1:0]  ptr,
  output logic                  valid,
  output logic [clog2w(N)-1:0]  idx
);

  localparam int IW = clog2w(N);

  int p;

  // Scan from the farthest offset back to ptr so the nearest hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      p = int'(ptr) + i;
      if (p >= N) p = p - N;
      if (req[p]) begin
        valid = 1'b1;
        idx   = IW'(p);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with a dead cycle
// between owners so no two buffers are ever enabled across a handover.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int MAXHOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         en,
  output logic [clog2w(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 turnaround
);

  localparam int IW = clog2w(N);
  localparam int CW = clog2w(MAXHOLD + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXHOLD);

  if (N < 1 || W < 1 || MAXHOLD < 1) begin : g_param_check
    $error("tristate_bus_arbiter: N, W and MAXHOLD must all be >= 1");
  end

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  state_t          state, nxt_state;
  logic [IW-1:0]   ptr, nxt_ptr;
  logic [IW-1:0]   nxt_gnt;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            others_req;
  logic            release_now;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_id <= '0;
      cnt    <= '0;
    end else begin
      state  <= nxt_state;
      ptr    <= nxt_ptr;
      gnt_id <= nxt_gnt;
      cnt    <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_gnt     = gnt_id;
    nxt_cnt     = cnt;
    others_req  = |(req & ~onehot(gnt_id));
    // Timeout only forces a release when someone else is actually waiting.
    release_now = done[gnt_id] | ~req[gnt_id] | ((cnt == CMAX) & others_req);
    unique case (state)
      IDLE, TURN: begin
        if (pick_valid) begin
          nxt_state = GRANT;
          nxt_gnt   = pick_idx;
          nxt_cnt   = CW'(1);
        end else begin
          nxt_state = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          nxt_state = TURN;
          nxt_ptr   = (int'(gnt_id) == N - 1) ? '0 : gnt_id + IW'(1);
        end else if (cnt != CMAX) begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    en         = (state == GRANT) ? onehot(gnt_id) : '0;
    busy       = (state == GRANT);
    turnaround = (state == TURN);
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed scenarios with a queued expectation per cycle, checked by an independent monitor.
module tb_tristate_bus_arbiter;

  localparam int N = 4;
  localparam int W = 4;
  localparam logic [W-1:0] DATA [N] = '{4'hA, 4'h5, 4'hC, 4'h3};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] en;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         turnaround;
  wire  [W-1:0] bus;

  typedef struct packed {
    logic [N-1:0] en;
    logic [1:0]   gid;
    logic         turn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(N), .W(W), .MAXHOLD(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .en         (en),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .turnaround (turnaround)
  );

  for (genvar i = 0; i < N; i++) begin : g_buf
    tristate_buf #(.W(W)) u_buf (
      .enable (en[i]),
      .a      (DATA[i]),
      .y      (bus)
    );
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Inputs applied now are sampled on the next rising edge; the expectation is for the cycle after it.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                      input logic [N-1:0] e_en, input logic [1:0] e_gid, input logic e_turn);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = rq;
    done  = dn;
    e.en   = e_en;
    e.gid  = e_gid;
    e.turn = e_turn;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   idx;
    forever begin
      @(posedge clk);
      #1;
      chk("onehot", int'($countones(en) <= 1), 1);
      chk("busy_eq_or_en", int'(busy), int'(|en));
      if ($countones(en) == 1) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (en[i]) idx = i;
        chk("bus_value", int'(bus), int'(DATA[idx]));
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("en", int'(en), int'(e.en));
        chk("turnaround", int'(turnaround), int'(e.turn));
        chk("busy", int'(busy), int'(|e.en));
        if (|e.en) chk("gnt_id", int'(gnt_id), int'(e.gid));
      end
    end
  end

  initial begin : driver
    // Reset held with all requests pending, then release.
    step(0, 4'hF, 4'h0, 4'h0, 0, 0);
    step(0, 4'hF, 4'h0, 4'h0, 0, 0);
    step(1, 4'hF, 4'h0, 4'h1, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    // Single request released by done.
    step(1, 4'h4, 4'h0, 4'h4, 2, 0);
    step(1, 4'h4, 4'h4, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    // Round robin from ptr=0; non-owner done bits ride along in the first grant cycle.
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    for (int o = 0; o < N; o++) begin
      step(1, 4'hF, 4'h0, 4'(1 << o), 2'(o), 0);
      step(1, 4'hF, 4'hF ^ 4'(1 << o), 4'(1 << o), 2'(o), 0);
      step(1, 4'hF, 4'(1 << o), 4'h0, 0, 1);
    end
    step(1, 4'hF, 4'h0, 4'h1, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    // Timeout handover between two persistent requesters.
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 4'h3, 4'h0, 4'h1, 0, 0);
    step(1, 4'h3, 4'h0, 4'h0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 4'h3, 4'h0, 4'h2, 1, 0);
    step(1, 4'h3, 4'h0, 4'h0, 0, 1);
    step(1, 4'h3, 4'h0, 4'h1, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    // Lone requester past saturation, with stray done[3] pulses.
    for (int i = 0; i < 20; i++) step(1, 4'h1, (i % 2 == 1) ? 4'h8 : 4'h0, 4'h1, 0, 0);
    step(1, 4'h0, 4'h0, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    // Reset while owner 2 holds the bus; pointer restarts at 0.
    step(1, 4'h4, 4'h0, 4'h4, 2, 0);
    step(1, 4'h4, 4'h0, 4'h4, 2, 0);
    step(0, 4'h4, 4'h0, 4'h0, 0, 0);
    step(1, 4'hC, 4'h0, 4'h4, 2, 0);
    step(1, 4'hC, 4'h4, 4'h0, 0, 1);
    step(1, 4'hC, 4'h0, 4'h8, 3, 0);
    step(1, 4'h0, 4'h0, 4'h0, 0, 1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);

    @(posedge clk);
    #3;
    chk("expect_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
